// File: rtl/yolo_max_pool_addr_gen.sv
// Max-pool window address generator: walks the output grid and emits the four
// input-map word addresses of each 2x2 window through a 2-stage valid/ready pipe.
module yolo_max_pool_addr_gen #(
  parameter int ROW_W   = 9,
  parameter int PITCH_W = 17,
  parameter int ADDR_W  = 26
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_idle,
  output logic               ap_done,
  input  logic [ROW_W-1:0]   cfg_rows,
  input  logic [ROW_W-1:0]   cfg_cols,
  input  logic [PITCH_W-1:0] cfg_pitch,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic               cfg_stride1,
  output logic [ADDR_W-1:0]  addr_data,
  output logic               addr_win_last,
  output logic               addr_last,
  output logic               addr_valid,
  input  logic               addr_ready
);

  localparam logic [ROW_W-1:0] ROW_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0]   rows_q, cols_q, out_rows_q, out_cols_q;
  logic [PITCH_W-1:0] pitch_q;
  logic [ADDR_W-1:0]  base_q;
  logic               stride1_q;

  logic [ROW_W-1:0]   orow, ocol;
  logic [1:0]         w;

  logic [ROW_W-1:0]   new_out_rows, new_out_cols;
  logic               start_ok, zero_frame, en, advance, last_coord;
  logic [ROW_W-1:0]   r, c;
  logic [ADDR_W-1:0]  prod;

  logic               s1_valid, s1_wlast, s1_last;
  logic [ADDR_W-1:0]  s1_prod;
  logic [ROW_W-1:0]   s1_c;

  assign new_out_rows = cfg_stride1 ? cfg_rows : (cfg_rows >> 1);
  assign new_out_cols = cfg_stride1 ? cfg_cols : (cfg_cols >> 1);
  assign zero_frame   = (new_out_rows == '0) || (new_out_cols == '0);
  assign start_ok     = (state == IDLE) && ap_start;

  // Single global enable: every stage and the counters move together.
  assign en         = ~addr_valid | addr_ready;
  assign advance    = (state == RUN) && en;
  assign last_coord = (orow == out_rows_q - ROW_ONE) && (ocol == out_cols_q - ROW_ONE)
                      && (w == 2'd3);

  assign ap_idle = (state == IDLE);
  assign ap_done = (state == DONE);

  // w[1] is dy, w[0] is dx. Stride-1 clamps only when stepping past the last row/col.
  always_comb begin
    if (stride1_q) begin
      r = (w[1] && (orow != rows_q - ROW_ONE)) ? orow + ROW_ONE : orow;
      c = (w[0] && (ocol != cols_q - ROW_ONE)) ? ocol + ROW_ONE : ocol;
    end else begin
      r = {orow[ROW_W-2:0], w[1]};
      c = {ocol[ROW_W-2:0], w[0]};
    end
  end

  assign prod = ADDR_W'(r) * ADDR_W'(pitch_q);

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ap_start) state_nxt = zero_frame ? DONE : RUN;
      RUN:     if (advance && last_coord) state_nxt = FLUSH;
      FLUSH:   if (addr_valid && addr_ready && addr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rows_q     <= '0;
      cols_q     <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      pitch_q    <= '0;
      base_q     <= '0;
      stride1_q  <= 1'b0;
    end else if (start_ok) begin
      rows_q     <= cfg_rows;
      cols_q     <= cfg_cols;
      out_rows_q <= new_out_rows;
      out_cols_q <= new_out_cols;
      pitch_q    <= cfg_pitch;
      base_q     <= cfg_base;
      stride1_q  <= cfg_stride1;
    end
  end

  // Counters park on the final coordinate once it has been issued.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || start_ok) begin
      orow <= '0;
      ocol <= '0;
      w    <= '0;
    end else if (advance && !last_coord) begin
      w <= w + 2'd1;
      if (w == 2'd3) begin
        if (ocol == out_cols_q - ROW_ONE) begin
          ocol <= '0;
          orow <= orow + ROW_ONE;
        end else begin
          ocol <= ocol + ROW_ONE;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid      <= 1'b0;
      s1_prod       <= '0;
      s1_c          <= '0;
      s1_wlast      <= 1'b0;
      s1_last       <= 1'b0;
      addr_valid    <= 1'b0;
      addr_data     <= '0;
      addr_win_last <= 1'b0;
      addr_last     <= 1'b0;
    end else if (en) begin
      s1_valid <= advance;
      if (advance) begin
        s1_prod  <= prod;
        s1_c     <= c;
        s1_wlast <= (w == 2'd3);
        s1_last  <= last_coord;
      end
      addr_valid    <= s1_valid;
      if (s1_valid) addr_data <= base_q + s1_prod + ADDR_W'(s1_c);
      addr_win_last <= s1_valid && s1_wlast;
      addr_last     <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_yolo_max_pool_addr_gen.sv
// Directed bench for yolo_max_pool_addr_gen: stride-2/stride-1 frames,
// backpressure, odd/zero sizes, address wrap and start/reset control.
module tb_yolo_max_pool_addr_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_start, ap_idle, ap_done;
  logic [8:0]  cfg_rows, cfg_cols;
  logic [16:0] cfg_pitch;
  logic [25:0] cfg_base;
  logic        cfg_stride1;
  logic [25:0] addr_data;
  logic        addr_win_last, addr_last, addr_valid, addr_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [25:0] got_d[$];
  bit          got_wl[$];
  bit          got_l[$];
  logic [25:0] exp_a [16];
  int          done_count, done_cyc, first_valid, last_beat_cyc;
  logic        idle_c1;

  always #5 ap_clk = ~ap_clk;

  yolo_max_pool_addr_gen dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_idle       (ap_idle),
    .ap_done       (ap_done),
    .cfg_rows      (cfg_rows),
    .cfg_cols      (cfg_cols),
    .cfg_pitch     (cfg_pitch),
    .cfg_base      (cfg_base),
    .cfg_stride1   (cfg_stride1),
    .addr_data     (addr_data),
    .addr_win_last (addr_win_last),
    .addr_last     (addr_last),
    .addr_valid    (addr_valid),
    .addr_ready    (addr_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Cycle 0 is the cycle in which ap_start is first presented in IDLE.
  task automatic run_frame(input logic [8:0] rows, input logic [8:0] cols,
                           input logic [16:0] pitch, input logic [25:0] base,
                           input logic s1, input bit bp, input bit hold, input int budget);
    bit          finished = 0;
    bit          stalled_prev = 0;
    logic [25:0] prev_data = '0;
    got_d.delete(); got_wl.delete(); got_l.delete();
    done_count = 0; done_cyc = -1; first_valid = -1; last_beat_cyc = -1; idle_c1 = 1'bx;
    cfg_rows = rows; cfg_cols = cols; cfg_pitch = pitch; cfg_base = base; cfg_stride1 = s1;
    ap_start = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      addr_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (cyc == 1) idle_c1 = ap_idle;
      if (stalled_prev) begin
        check("stall_valid", addr_valid, 1);
        check("stall_data", addr_data, prev_data);
      end
      if (addr_valid && first_valid < 0) first_valid = cyc;
      if (addr_valid && addr_ready) begin
        got_d.push_back(addr_data);
        got_wl.push_back(addr_win_last);
        got_l.push_back(addr_last);
        last_beat_cyc = cyc;
      end
      stalled_prev = addr_valid && !addr_ready;
      prev_data    = addr_data;
      if (ap_done) begin
        done_count++;
        done_cyc = cyc;
        ap_start = 1'b0;
      end
      if (cyc > 0 && !hold) ap_start = 1'b0;
      if (done_count > 0 && ap_idle) begin
        finished = 1;
        break;
      end
      tick();
    end
    ap_start = 1'b0;
    check("frame_finished", finished, 1);
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, ".beats"}, got_d.size(), n);
    if (got_d.size() == n)
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s.addr[%0d]", tag, i), got_d[i], exp_a[i]);
        check($sformatf("%s.win_last[%0d]", tag, i), got_wl[i], (i % 4) == 3);
        check($sformatf("%s.last[%0d]", tag, i), got_l[i], i == n - 1);
      end
  endtask

  initial begin
    int last_cnt;
    int dc;
    ap_rst = 1'b1; ap_start = 1'b0; addr_ready = 1'b1;
    cfg_rows = '0; cfg_cols = '0; cfg_pitch = '0; cfg_base = '0; cfg_stride1 = 1'b0;
    repeat (3) tick();
    check("rst.idle", ap_idle, 1);
    check("rst.done", ap_done, 0);
    check("rst.valid", addr_valid, 0);
    check("rst.data", addr_data, 0);
    check("rst.win_last", addr_win_last, 0);
    check("rst.last", addr_last, 0);
    ap_rst = 1'b0;
    tick();

    // Stride-2 4x4, no backpressure.
    exp_a = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    run_frame(4, 4, 4, 0, 0, 0, 0, 200);
    check_seq("s2", 16);
    check("s2.idle_c1", idle_c1, 0);
    check("s2.first_valid", first_valid, 3);
    check("s2.done_cyc", done_cyc, 19);
    check("s2.done_count", done_count, 1);

    // Stride-1 2x2 with edge replication.
    exp_a = '{100, 101, 102, 103, 101, 101, 103, 103,
              102, 103, 102, 103, 103, 103, 103, 103};
    run_frame(2, 2, 2, 100, 1, 0, 0, 200);
    check_seq("s1", 16);
    check("s1.done_count", done_count, 1);

    // Backpressure 1,0,0,1 on the stride-2 frame.
    exp_a = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    run_frame(4, 4, 4, 0, 0, 1, 0, 400);
    check_seq("bp", 16);
    check("bp.done_after_last", done_cyc, last_beat_cyc + 1);
    check("bp.done_count", done_count, 1);

    // Odd 3x3 stride-2: trailing row/col dropped, single window.
    exp_a[0] = 26'h10; exp_a[1] = 26'h11; exp_a[2] = 26'h18; exp_a[3] = 26'h19;
    run_frame(3, 3, 8, 26'h10, 0, 0, 0, 200);
    check_seq("odd", 4);

    // rows=1 stride-2: empty grid, straight to DONE.
    run_frame(1, 4, 4, 0, 0, 0, 0, 50);
    check("zero.beats", got_d.size(), 0);
    check("zero.done_cyc", done_cyc, 1);
    check("zero.done_count", done_count, 1);

    // Max rows/pitch/base: addresses wrap modulo 2^26.
    run_frame(511, 2, 17'h1FFFF, 26'h3FFFFFF, 0, 0, 0, 1500);
    check("wrap.beats", got_d.size(), 1020);
    if (got_d.size() == 1020) begin
      check("wrap.a0", got_d[0], 26'h3FFFFFF);
      check("wrap.a1", got_d[1], 26'h0000000);
      check("wrap.a2", got_d[2], 26'h001FFFE);
      check("wrap.a3", got_d[3], 26'h001FFFF);
      check("wrap.a1016", got_d[1016], 26'h3F7FE03);
      check("wrap.a1017", got_d[1017], 26'h3F7FE04);
      check("wrap.a1018", got_d[1018], 26'h3F9FE02);
      check("wrap.a1019", got_d[1019], 26'h3F9FE03);
      check("wrap.last1019", got_l[1019], 1);
      last_cnt = 0;
      foreach (got_l[i]) if (got_l[i]) last_cnt++;
      check("wrap.last_count", last_cnt, 1);
    end

    // ap_start held high for the whole frame.
    exp_a = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    run_frame(4, 4, 4, 0, 0, 0, 1, 200);
    check_seq("hold", 16);
    check("hold.done_count", done_count, 1);

    // Reset mid-frame abandons the frame.
    cfg_rows = 4; cfg_cols = 4; cfg_pitch = 4; cfg_base = 0; cfg_stride1 = 0;
    addr_ready = 1'b1;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick(); tick();
    check("rst_mid.valid_before", addr_valid, 1);
    ap_rst = 1'b1;
    tick();
    check("rst_mid.valid", addr_valid, 0);
    check("rst_mid.idle", ap_idle, 1);
    check("rst_mid.done", ap_done, 0);
    ap_rst = 1'b0;
    dc = 0;
    repeat (8) begin
      if (ap_done) dc++;
      tick();
    end
    check("rst_mid.no_done", dc, 0);

    // Clean frame after the reset.
    run_frame(4, 4, 4, 0, 0, 0, 0, 200);
    check_seq("post_rst", 16);
    check("post_rst.first_valid", first_valid, 3);
    check("post_rst.done_count", done_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
